// File: rtl/cycle_pkg.sv
// Shared types for the bit-serial cycle sequencer: word widths, FSM states and
// the latched command record.
package cycle_pkg;

  localparam int unsigned WORD_W = 32;
  localparam int unsigned PO_W   = 2;

  typedef enum logic [2:0] {
    StIdle,
    StShift,
    StStrobe,
    StWait,
    StCapture,
    StDrain,
    StCollect,
    StResp
  } ctrl_state_t;

  typedef struct packed {
    logic [WORD_W-1:0] word;
    logic              ld;
    logic              pa;
    logic [2:0]        id;
  } cmd_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first requester at or after ptr wins, and
// the pointer moves to the slot just past the winner.
module rr_arbiter #(
  parameter int unsigned NREQ = 2,
  localparam int unsigned PtrW = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0] req,
  input  logic [PtrW-1:0] ptr,
  output logic [NREQ-1:0] grant,
  output logic [PtrW-1:0] grant_idx,
  output logic [PtrW-1:0] next_ptr,
  output logic            found
);

  int unsigned idx;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    next_ptr  = ptr;
    found     = 1'b0;
    idx       = 0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      idx = (32'(ptr) + k) % NREQ;
      if (!found && req[idx]) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
        grant_idx  = PtrW'(idx);
        next_ptr   = PtrW'((idx + 1) % NREQ);
      end
    end
  end

endmodule

// File: rtl/cycle_serial_ctrl.sv
// Arbitrates parallel commands onto the bit-serial cycle interface and
// deserialises the serial result into a tagged response. All outputs registered.
module cycle_serial_ctrl
  import cycle_pkg::*;
#(
  parameter int unsigned NREQ        = 2,
  parameter int unsigned RESULT_WAIT = 4,
  parameter int unsigned Q_LAT       = 2,
  localparam int unsigned IdW        = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [NREQ*32-1:0]   req_word,
  input  logic [NREQ-1:0]      req_ld,
  input  logic [NREQ-1:0]      req_pa,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [WORD_W-1:0]    rsp_word,
  output logic [PO_W-1:0]      rsp_po,
  output logic [IdW-1:0]       rsp_id,
  output logic                 ser_d,
  output logic                 ser_de,
  output logic                 ser_ld,
  output logic                 ser_pa,
  output logic                 ser_qe,
  input  logic                 ser_q,
  input  logic [PO_W-1:0]      ser_po,
  output logic                 busy
);

  localparam int unsigned WaitW = (RESULT_WAIT > 1) ? $clog2(RESULT_WAIT) : 1;

  ctrl_state_t       state_q, state_d;
  logic [5:0]        cnt_q, cnt_d;
  logic [WaitW-1:0]  wait_q, wait_d;
  logic [IdW-1:0]    ptr_q, ptr_d;
  cmd_t              cmd_q, cmd_d;
  logic [WORD_W-1:0] rsp_word_q, rsp_word_d;
  logic [PO_W-1:0]   rsp_po_q, rsp_po_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [NREQ-1:0]   req_ready_q, req_ready_d;
  logic              ser_d_q, ser_d_d, ser_de_q, ser_de_d;
  logic              ser_ld_q, ser_ld_d, ser_pa_q, ser_pa_d;
  logic              ser_qe_q, ser_qe_d, busy_q, busy_d;

  logic [NREQ-1:0]   grant;
  logic [IdW-1:0]    grant_idx, next_ptr;
  logic              found;

  rr_arbiter #(.NREQ(NREQ)) u_arb (
    .req       (req_valid),
    .ptr       (ptr_q),
    .grant     (grant),
    .grant_idx (grant_idx),
    .next_ptr  (next_ptr),
    .found     (found)
  );

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    wait_d      = wait_q;
    ptr_d       = ptr_q;
    cmd_d       = cmd_q;
    rsp_word_d  = rsp_word_q;
    rsp_po_d    = rsp_po_q;
    rsp_valid_d = 1'b0;
    req_ready_d = '0;
    ser_d_d     = 1'b0;
    ser_de_d    = 1'b0;
    ser_ld_d    = 1'b0;
    ser_pa_d    = 1'b0;
    ser_qe_d    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (found) begin
          state_d     = StShift;
          req_ready_d = grant;
          ptr_d       = next_ptr;
          cmd_d.word  = req_word[32'(grant_idx) * WORD_W +: WORD_W];
          cmd_d.ld    = req_ld[grant_idx];
          cmd_d.pa    = req_pa[grant_idx];
          cmd_d.id    = 3'(grant_idx);
          cnt_d       = '0;
          ser_d_d     = cmd_d.word[WORD_W-1];
        end
      end
      StShift: begin
        if (cnt_q == 6'd31) begin
          state_d  = StStrobe;
          ser_de_d = 1'b1;
          ser_ld_d = cmd_q.ld;
          ser_pa_d = cmd_q.pa;
        end else begin
          cnt_d   = cnt_q + 6'd1;
          ser_d_d = cmd_q.word[5'(6'd30 - cnt_q)];
        end
      end
      StStrobe: begin
        if (RESULT_WAIT == 0) begin
          state_d  = StCapture;
          ser_qe_d = 1'b1;
        end else begin
          state_d = StWait;
          wait_d  = '0;
        end
      end
      StWait: begin
        if (wait_q == WaitW'(RESULT_WAIT - 1)) begin
          state_d  = StCapture;
          ser_qe_d = 1'b1;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end
      StCapture: begin
        cnt_d   = '0;
        // With Q_LAT=1 the edge right after QE already carries bit 31.
        state_d = (Q_LAT <= 1) ? StCollect : StDrain;
      end
      StDrain: begin
        if (cnt_q == 6'(Q_LAT - 2)) begin
          state_d = StCollect;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 6'd1;
        end
      end
      StCollect: begin
        rsp_word_d = {rsp_word_q[WORD_W-2:0], ser_q};
        if (cnt_q == 6'd0) rsp_po_d = ser_po;
        if (cnt_q == 6'd31) begin
          state_d     = StResp;
          rsp_valid_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 6'd1;
        end
      end
      StResp: begin
        if (rsp_ready) state_d = StIdle;
        else           rsp_valid_d = 1'b1;
      end
    endcase
    busy_d = (state_d != StIdle);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      wait_q      <= '0;
      ptr_q       <= '0;
      cmd_q       <= '0;
      rsp_word_q  <= '0;
      rsp_po_q    <= '0;
      rsp_valid_q <= 1'b0;
      req_ready_q <= '0;
      ser_d_q     <= 1'b0;
      ser_de_q    <= 1'b0;
      ser_ld_q    <= 1'b0;
      ser_pa_q    <= 1'b0;
      ser_qe_q    <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      wait_q      <= wait_d;
      ptr_q       <= ptr_d;
      cmd_q       <= cmd_d;
      rsp_word_q  <= rsp_word_d;
      rsp_po_q    <= rsp_po_d;
      rsp_valid_q <= rsp_valid_d;
      req_ready_q <= req_ready_d;
      ser_d_q     <= ser_d_d;
      ser_de_q    <= ser_de_d;
      ser_ld_q    <= ser_ld_d;
      ser_pa_q    <= ser_pa_d;
      ser_qe_q    <= ser_qe_d;
      busy_q      <= busy_d;
    end
  end

  // Upper id bits are spare when NREQ is below 8.
  logic unused_id;
  assign unused_id = ^cmd_q.id;

  assign req_ready = req_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_word  = rsp_word_q;
  assign rsp_po    = rsp_po_q;
  assign rsp_id    = cmd_q.id[IdW-1:0];
  assign ser_d     = ser_d_q;
  assign ser_de    = ser_de_q;
  assign ser_ld    = ser_ld_q;
  assign ser_pa    = ser_pa_q;
  assign ser_qe    = ser_qe_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_cycle_serial_ctrl.sv
// Bench for cycle_serial_ctrl: two instances (default timing and RESULT_WAIT=0/Q_LAT=1),
// each paired with a stub cycle core that answers R = ~Din and phase_out = 2'b10.
module tb_cycle_serial_ctrl;

  typedef struct {
    int          d;
    int          r;
    logic [31:0] word;
    logic        ld;
    logic        pa;
    logic [31:0] exp_word;
    logic [1:0]  exp_po;
    int          exp_qe;
    int          exp_rsp;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  req_valid [2];
  logic [1:0]  req_ready [2];
  logic [63:0] req_word  [2];
  logic [1:0]  req_ld    [2];
  logic [1:0]  req_pa    [2];
  logic        rsp_valid [2];
  logic        rsp_ready [2];
  logic [31:0] rsp_word  [2];
  logic [1:0]  rsp_po    [2];
  logic        rsp_id    [2];
  logic        ser_d     [2];
  logic        ser_de    [2];
  logic        ser_ld    [2];
  logic        ser_pa    [2];
  logic        ser_qe    [2];
  logic        busy      [2];

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    localparam int unsigned RW = (g == 0) ? 4 : 0;
    localparam int unsigned QL = (g == 0) ? 2 : 1;
    logic        ser_q  = 1'b0;
    logic [1:0]  ser_po = 2'b00;
    logic [31:0] din_sr  = '0;
    logic [31:0] din_lat = '0;
    logic [31:0] r;

    cycle_serial_ctrl #(.NREQ(2), .RESULT_WAIT(RW), .Q_LAT(QL)) u_dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req_valid (req_valid[g]),
      .req_ready (req_ready[g]),
      .req_word  (req_word[g]),
      .req_ld    (req_ld[g]),
      .req_pa    (req_pa[g]),
      .rsp_valid (rsp_valid[g]),
      .rsp_ready (rsp_ready[g]),
      .rsp_word  (rsp_word[g]),
      .rsp_po    (rsp_po[g]),
      .rsp_id    (rsp_id[g]),
      .ser_d     (ser_d[g]),
      .ser_de    (ser_de[g]),
      .ser_ld    (ser_ld[g]),
      .ser_pa    (ser_pa[g]),
      .ser_qe    (ser_qe[g]),
      .ser_q     (ser_q),
      .ser_po    (ser_po),
      .busy      (busy[g])
    );

    // Serial wrapper: D shifts in until DE, which latches the last 32 bits.
    always @(posedge clk) begin
      if (ser_de[g]) din_lat <= din_sr;
      else           din_sr  <= {din_sr[30:0], ser_d[g]};
    end

    // Stub core: bit 31 of ~Din is on Q at the edge QL clocks after the QE edge.
    initial begin
      forever begin
        @(posedge clk);
        if (ser_qe[g] === 1'b1) begin
          r = ~din_lat;
          repeat (QL - 1) @(posedge clk);
          #1;
          ser_po = 2'b10;
          ser_q  = r[31];
          for (int i = 30; i >= 0; i--) begin
            @(posedge clk);
            #1 ser_q = r[i];
          end
          @(posedge clk);
          #1;
          ser_po = 2'b00;
          ser_q  = 1'b0;
        end
      end
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  function automatic logic [63:0] outs(input int d);
    return 64'({req_ready[d], rsp_valid[d], rsp_word[d], rsp_po[d], rsp_id[d],
                ser_d[d], ser_de[d], ser_ld[d], ser_pa[d], ser_qe[d], busy[d]});
  endfunction

  // Runs one single-requester transaction; valid must be raised while the DUT is idle.
  task automatic run_vec(input vec_t v);
    logic [31:0] bits;
    logic [31:0] rw;
    logic [2:0]  post;
    logic [1:0]  rdy, rpo;
    logic        de_ld, de_pa, de_d, rid, busy0;
    int          de_t, qe_t, rsp_t, wait_n;
    bits = '0; rw = '0; post = 3'b111; rpo = '0; rid = 1'b0;
    de_ld = 1'b0; de_pa = 1'b0; de_d = 1'b1; busy0 = 1'b0;
    de_t = -1; qe_t = -1; rsp_t = -1; wait_n = 0;
    req_word[v.d][32*v.r +: 32] = v.word;
    req_ld[v.d][v.r]    = v.ld;
    req_pa[v.d][v.r]    = v.pa;
    req_valid[v.d][v.r] = 1'b1;
    do begin
      @(negedge clk);
      wait_n++;
    end while (req_ready[v.d] == 2'b00 && wait_n < 20);
    rdy   = req_ready[v.d];
    busy0 = busy[v.d];
    chk("grant_latency", 64'(wait_n), 64'd1);
    chk("grant_onehot", 64'(rdy), 64'(2'b01 << v.r));
    chk("busy_in_shift", 64'(busy0), 64'd1);
    for (int t = 0; t < 200 && rsp_t < 0; t++) begin
      if (t > 0) @(negedge clk);
      if (t == 1) req_valid[v.d][v.r] = 1'b0;
      if (t < 32) bits[31-t] = ser_d[v.d];
      if (de_t >= 0 && t == de_t + 1) post = {ser_de[v.d], ser_ld[v.d], ser_pa[v.d]};
      if (ser_de[v.d] && de_t < 0) begin
        de_t  = t;
        de_ld = ser_ld[v.d];
        de_pa = ser_pa[v.d];
        de_d  = ser_d[v.d];
      end
      if (ser_qe[v.d] && qe_t < 0) qe_t = t;
      if (rsp_valid[v.d]) begin
        rsp_t = t;
        rw    = rsp_word[v.d];
        rpo   = rsp_po[v.d];
        rid   = rsp_id[v.d];
      end
    end
    chk("ser_d_stream", 64'(bits), 64'(v.word));
    chk("de_cycle", 64'(de_t), 64'(32));
    chk("de_ld", 64'(de_ld), 64'(v.ld));
    chk("de_pa", 64'(de_pa), 64'(v.pa));
    chk("de_d_zero", 64'(de_d), 64'd0);
    chk("strobe_release", 64'(post), 64'd0);
    chk("qe_cycle", 64'(qe_t), 64'(v.exp_qe));
    chk("rsp_cycle", 64'(rsp_t), 64'(v.exp_rsp));
    chk("rsp_word", 64'(rw), 64'(v.exp_word));
    chk("rsp_po", 64'(rpo), 64'(v.exp_po));
    chk("rsp_id", 64'(rid), 64'(v.r));
    @(negedge clk);
    chk("rsp_drop", 64'({rsp_valid[v.d], busy[v.d]}), 64'd0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vec_t        vecs [5];
    logic [1:0]  grants [4];
    logic        ids    [4];
    logic [31:0] words  [4];
    int          n_g, n_rsp, cyc, bad;

    vecs[0] = '{0, 0, 32'hDEADBEEF, 1'b1, 1'b0, 32'h21524110, 2'b10, 37, 71};
    vecs[1] = '{0, 1, 32'h12345678, 1'b0, 1'b1, 32'hEDCBA987, 2'b10, 37, 71};
    vecs[2] = '{1, 0, 32'h80000001, 1'b1, 1'b1, 32'h7FFFFFFE, 2'b10, 33, 66};
    vecs[3] = '{1, 1, 32'h00000000, 1'b0, 1'b0, 32'hFFFFFFFF, 2'b10, 33, 66};
    vecs[4] = '{0, 1, 32'hFFFFFFFF, 1'b0, 1'b0, 32'h00000000, 2'b10, 37, 71};

    for (int d = 0; d < 2; d++) begin
      req_valid[d] = '0;
      req_word[d]  = '0;
      req_ld[d]    = '0;
      req_pa[d]    = '0;
      rsp_ready[d] = 1'b1;
    end

    // Reset held with a requester already valid.
    rst_n           = 1'b0;
    req_word[0]     = {32'h0, 32'hDEADBEEF};
    req_ld[0]       = 2'b01;
    req_valid[0]    = 2'b01;
    repeat (5) begin
      @(negedge clk);
      chk("reset_outs_a", outs(0), 64'd0);
      chk("reset_outs_b", outs(1), 64'd0);
    end
    rst_n = 1'b1;
    #1;
    chk("post_reset_a", outs(0), 64'd0);
    chk("post_reset_b", outs(1), 64'd0);

    foreach (vecs[i]) run_vec(vecs[i]);

    // Two requesters valid continuously: strict alternation from pointer 0.
    req_word[0]  = {32'h0F0F0F0F, 32'hA5A5A5A5};
    req_ld[0]    = 2'b00;
    req_pa[0]    = 2'b00;
    req_valid[0] = 2'b11;
    n_g = 0; n_rsp = 0; cyc = 0;
    for (int i = 0; i < 4; i++) begin
      grants[i] = '0;
      ids[i]    = 1'b0;
      words[i]  = '0;
    end
    while (n_rsp < 4 && cyc < 500) begin
      @(negedge clk);
      cyc++;
      if (req_ready[0] != 2'b00 && n_g < 4) begin
        grants[n_g] = req_ready[0];
        n_g++;
      end
      if (rsp_valid[0]) begin
        ids[n_rsp]   = rsp_id[0];
        words[n_rsp] = rsp_word[0];
        n_rsp++;
        if (n_rsp == 4) req_valid[0] = 2'b00;
      end
    end
    req_valid[0] = 2'b00;
    for (int i = 0; i < 4; i++) begin
      chk("rr_grant", 64'(grants[i]), (i % 2 == 0) ? 64'h1 : 64'h2);
      chk("rr_id", 64'(ids[i]), 64'(i % 2));
      chk("rr_word", 64'(words[i]), (i % 2 == 0) ? 64'h5A5A5A5A : 64'hF0F0F0F0);
    end
    @(negedge clk);

    // Response back-pressure for 10 clocks while another requester waits.
    rsp_ready[0] = 1'b0;
    req_word[0]  = {32'h00000001, 32'h0000FFFF};
    req_valid[0] = 2'b01;
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (req_ready[0] == 2'b00 && cyc < 20);
    @(negedge clk);
    req_valid[0] = 2'b10;
    cyc = 0;
    while (!rsp_valid[0] && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    chk("hold_first_word", 64'(rsp_word[0]), 64'hFFFF0000);
    bad = 0;
    repeat (10) begin
      @(negedge clk);
      if (!rsp_valid[0] || rsp_word[0] != 32'hFFFF0000 || rsp_po[0] != 2'b10 ||
          rsp_id[0] != 1'b0 || req_ready[0] != 2'b00) bad++;
    end
    chk("hold_stable", 64'(bad), 64'd0);
    rsp_ready[0] = 1'b1;
    @(negedge clk);
    chk("hold_release", 64'({rsp_valid[0], busy[0], req_ready[0]}), 64'd0);
    @(negedge clk);
    chk("grant_after_rsp", 64'(req_ready[0]), 64'h2);
    @(negedge clk);
    req_valid[0] = 2'b00;
    cyc = 0;
    while (!rsp_valid[0] && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    chk("waiter_word", 64'(rsp_word[0]), 64'hFFFFFFFE);
    chk("waiter_id", 64'(rsp_id[0]), 64'd1);
    @(negedge clk);

    // Reset pulse during SHIFT bit 10 aborts the transaction.
    req_word[0]  = {32'h0, 32'hCAFEF00D};
    req_valid[0] = 2'b01;
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (req_ready[0] == 2'b00 && cyc < 20);
    for (int t = 1; t <= 10; t++) begin
      @(negedge clk);
      if (t == 1) req_valid[0] = 2'b00;
    end
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    bad = 0;
    repeat (100) begin
      @(negedge clk);
      if (ser_de[0] || ser_qe[0] || rsp_valid[0] || busy[0]) bad++;
    end
    chk("abort_quiet", 64'(bad), 64'd0);
    // Both valid again: a reset pointer must pick requester 0.
    req_word[0][63:32] = 32'h11111111;
    req_valid[0][1]    = 1'b1;
    run_vec('{0, 0, 32'h13579BDF, 1'b1, 1'b1, 32'hECA86420, 2'b10, 37, 71});
    req_valid[0] = 2'b00;
    repeat (3) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
